// File: rtl/alu_gate_if.sv
// Operand/result bundle between the execute-stage issue logic and the
// bitwise-logic unit. The master drives operands and the function code;
// the slave (the unit) returns the registered result and status flags.
interface alu_gate_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  valid_i;
    logic [DATA_WIDTH-1:0] rs1_data_i;
    logic [DATA_WIDTH-1:0] rs2_data_i;
    logic [2:0]            func_i;
    logic [DATA_WIDTH-1:0] rd_data_o;
    logic                  valid_o;
    logic                  zero_o;
    logic                  invalid_o;

    modport master (
        output valid_i, rs1_data_i, rs2_data_i, func_i,
        input  rd_data_o, valid_o, zero_o, invalid_o
    );

    modport slave (
        input  valid_i, rs1_data_i, rs2_data_i, func_i,
        output rd_data_o, valid_o, zero_o, invalid_o
    );
endinterface

// File: rtl/alu_gate_unit.sv
// Bitwise-logic execution unit: AND / OR / XOR / NOT on two register-file
// operands, one-cycle registered result for write-back. Codes with the top
// bit set are undefined and yield a zero result with the invalid flag raised.
module alu_gate_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic       clk_i,
    input  logic       rst_i,
    alu_gate_if.slave  bus
);

    logic [DATA_WIDTH-1:0] result_p0;
    logic                  invalid_p0;

    logic [DATA_WIDTH-1:0] rd_data_p1;
    logic                  vld_p1;
    logic                  zero_p1;
    logic                  invalid_p1;

    // ---- stage p0: combinational function decode and evaluation ----
    // Select the bitwise operation; undefined codes produce zero.
    always_comb begin
        result_p0  = '0;
        invalid_p0 = 1'b0;
        unique casez (bus.func_i)
            3'b000:  result_p0 = bus.rs1_data_i & bus.rs2_data_i;
            3'b001:  result_p0 = bus.rs1_data_i | bus.rs2_data_i;
            3'b010:  result_p0 = bus.rs1_data_i ^ bus.rs2_data_i;
            3'b011:  result_p0 = ~bus.rs1_data_i;
            default: invalid_p0 = 1'b1;
        endcase
    end

    // ---- stage p1: output register, result and flags held when idle ----
    // Capture accepted operations; reset wins over a same-cycle operation.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_p1 <= '0;
            vld_p1     <= 1'b0;
            zero_p1    <= 1'b1;
            invalid_p1 <= 1'b0;
        end else begin
            vld_p1 <= bus.valid_i;
            if (bus.valid_i) begin
                rd_data_p1 <= result_p0;
                zero_p1    <= ~|result_p0;
                invalid_p1 <= invalid_p0;
            end
        end
    end

    assign bus.rd_data_o = rd_data_p1;
    assign bus.valid_o   = vld_p1;
    assign bus.zero_o    = zero_p1;
    assign bus.invalid_o = invalid_p1;

endmodule

// File: tb/tb_alu_gate_unit.sv
// Bench for alu_gate_unit: directed operations, invalid codes, hold
// behaviour, and a long random stream with a reset in the middle, all
// compared against a truth-table reference model of the unit's outputs.
module tb_alu_gate_unit;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_gate_if #(.DATA_WIDTH(W)) bus ();

    alu_gate_unit #(.DATA_WIDTH(W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Expected output state kept by the reference model.
    logic [W-1:0] exp_data  = '0;
    logic         exp_valid = 1'b0;
    logic         exp_zero  = 1'b1;
    logic         exp_inv   = 1'b0;

    // Truth table per operation, indexed by {rs1_bit, rs2_bit}.
    function automatic logic [3:0] truth_table(input logic [2:0] f);
        case (f)
            3'd0:    return 4'b1000; // AND
            3'd1:    return 4'b1110; // OR
            3'd2:    return 4'b0110; // XOR
            3'd3:    return 4'b0011; // NOT of rs1
            default: return 4'b0000;
        endcase
    endfunction

    // Advance the model by one rising edge with the inputs just applied.
    task automatic model_edge(input logic r, input logic v, input logic [2:0] f,
                              input logic [W-1:0] a, input logic [W-1:0] b);
        logic [3:0]   tt;
        logic [W-1:0] res;
        int           ones;
        if (r) begin
            exp_data = '0; exp_valid = 1'b0; exp_zero = 1'b1; exp_inv = 1'b0;
        end else if (!v) begin
            exp_valid = 1'b0;
        end else begin
            tt   = truth_table(f);
            res  = '0;
            ones = 0;
            for (int i = 0; i < W; i++) begin
                res[i] = tt[{a[i], b[i]}];
                if (res[i]) ones++;
            end
            exp_data  = res;
            exp_valid = 1'b1;
            exp_zero  = (ones == 0);
            exp_inv   = (int'(f) >= 4);
        end
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".data"},  bus.rd_data_o,          exp_data);
        chk({tag, ".valid"}, {{(W-1){1'b0}}, bus.valid_o},   {{(W-1){1'b0}}, exp_valid});
        chk({tag, ".zero"},  {{(W-1){1'b0}}, bus.zero_o},    {{(W-1){1'b0}}, exp_zero});
        chk({tag, ".inv"},   {{(W-1){1'b0}}, bus.invalid_o}, {{(W-1){1'b0}}, exp_inv});
    endtask

    // Apply inputs away from the edge, clock once, update model, check outputs.
    task automatic cyc(input string tag, input logic r, input logic v, input logic [2:0] f,
                       input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        rst = r; bus.valid_i = v; bus.func_i = f;
        bus.rs1_data_i = a; bus.rs2_data_i = b;
        @(posedge clk);
        model_edge(r, v, f, a, b);
        #1;
        chk_all(tag);
    endtask

    localparam logic [W-1:0] A = 32'hF0F0_A5A5;
    localparam logic [W-1:0] B = 32'h0FF0_5A5A;

    initial begin
        logic [W-1:0] ra, rb, held;
        logic [2:0]   rf;

        bus.valid_i = 1'b1; bus.func_i = 3'd0;
        bus.rs1_data_i = A; bus.rs2_data_i = B;

        // Reset for two cycles while an operation is offered.
        cyc("reset0", 1'b1, 1'b1, 3'd0, A, B);
        cyc("reset1", 1'b1, 1'b1, 3'd1, A, B);
        chk("reset.data_const", bus.rd_data_o, '0);

        // Directed operations with known results.
        cyc("and", 1'b0, 1'b1, 3'b000, A, B);
        chk("and.const", bus.rd_data_o, 32'h00F0_0000);
        cyc("or",  1'b0, 1'b1, 3'b001, A, B);
        chk("or.const",  bus.rd_data_o, 32'hFFF0_FFFF);
        cyc("xor", 1'b0, 1'b1, 3'b010, A, B);
        chk("xor.const", bus.rd_data_o, 32'hFF00_FFFF);
        cyc("not", 1'b0, 1'b1, 3'b011, A, B);
        chk("not.const", bus.rd_data_o, 32'h0F0F_5A5A);

        // Undefined codes.
        cyc("inv100", 1'b0, 1'b1, 3'b100, A, B);
        chk("inv100.flag", {31'b0, bus.invalid_o}, 32'd1);
        cyc("inv111", 1'b0, 1'b1, 3'b111, A, B);
        chk("inv111.zero", {31'b0, bus.zero_o}, 32'd1);
        cyc("not_after_inv", 1'b0, 1'b1, 3'b011, A, B);

        // Zero result, then hold while idle with random inputs.
        cyc("and_zero", 1'b0, 1'b1, 3'b000, 32'hFFFF_FFFF, 32'h0);
        chk("and_zero.zflag", {31'b0, bus.zero_o}, 32'd1);
        held = bus.rd_data_o;
        for (int i = 0; i < 3; i++) begin
            rf = 3'($urandom_range(0, 7));
            cyc("hold", 1'b0, 1'b0, rf, $urandom, $urandom);
        end
        chk("hold.data_const", bus.rd_data_o, '0);

        // Long back-to-back random stream with a reset in the middle.
        for (int i = 0; i < 10000; i++) begin
            ra = $urandom; rb = $urandom;
            if ($urandom_range(0, 99) < 5) rf = 3'(4 + $urandom_range(0, 3));
            else                           rf = 3'($urandom_range(0, 3));
            if (i == 5000) cyc("rand_reset", 1'b1, 1'b1, rf, ra, rb);
            else           cyc("rand",       1'b0, 1'b1, rf, ra, rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
